// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: steers ALU or load results onto the single
// register-file write port, favouring loads with a bounded ALU wait.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       conflict_cnt
);

  // Handshake: a source transfers on a cycle where valid && ready. ready is
  // combinational from the valids and the priority state, is never high
  // without its valid, and at most one ready is high per cycle. A source
  // keeps valid/rd/data stable until it sees ready.

  typedef enum logic {
    MEM_PRI = 1'b0,
    ALU_PRI = 1'b1
  } arb_state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic [3:0] starve_inc;
  logic       grant_alu;
  logic       grant_mem;

  always_comb begin
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    starve_inc = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
    if (rst_n) begin
      grant_alu = alu_valid && (!mem_valid || state == ALU_PRI);
      grant_mem = mem_valid && !grant_alu;
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= MEM_PRI;
      starve_cnt   <= 4'd0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      conflict_cnt <= 16'd0;
    end else begin
      if (alu_valid && mem_valid && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;

      // Any ALU grant ends the starvation episode, so priority falls back to loads.
      if (grant_alu) begin
        starve_cnt <= 4'd0;
        state      <= MEM_PRI;
      end else if (alu_valid) begin
        starve_cnt <= starve_inc;
        if (starve_inc == LIMIT)
          state <= ALU_PRI;
      end

      // x0 writes are consumed but suppressed at the write enable.
      if (grant_alu) begin
        rf_we    <= |alu_rd;
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
      end else if (grant_mem) begin
        rf_we    <= |mem_rd;
        rf_waddr <= mem_rd;
        rf_wdata <= mem_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus hand-written
// sequences for reset, starvation, saturation and mid-operation reset.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] conflict_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .conflict_cnt (conflict_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adat;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = mdat;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        ear;
    logic        emr;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [15:0] econf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [9:0]  pat;
    logic [31:0] acnt;
    logic [31:0] mcnt;
    logic        exp_a;

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 16'd0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 16'd0};
    vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234,
                1'b0, 1'b1, 1'b0, 5'd0, 32'h1234, 16'd0};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hA5,
                1'b0, 1'b1, 1'b1, 5'd9, 32'hA5, 16'd0};
    vecs[4] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22,
                1'b0, 1'b1, 1'b1, 5'd4, 32'h22, 16'd1};
    vecs[5] = '{1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 16'd1};
    vecs[6] = '{1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b0, 5'd0, 32'h77, 16'd1};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 5'd0, 32'h77, 16'd1};

    // reset held with both sources requesting
    rst_n = 1'b0;
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_mem_ready", 32'(mem_ready), 32'd1);
    chk("rel_alu_ready", 32'(alu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_rf_we", 32'(rf_we), 32'd1);
    chk("rel_rf_waddr", 32'(rf_waddr), 32'd2);
    chk("rel_rf_wdata", rf_wdata, 32'hB2);
    chk("rel_conflict", 32'(conflict_cnt), 32'd1);

    // vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].ewe));
      chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].ewa));
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].ewd);
      chk($sformatf("v%0d_conflict", i), 32'(conflict_cnt), 32'(vecs[i].econf));
    end

    // starvation: grant sequence M,M,M,M,A,M,M,M,M,A
    do_reset();
    pat  = 10'b10_0001_0000;
    acnt = 32'd0;
    mcnt = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd1, 32'hA000_0000 + acnt, 1'b1, 5'd2, 32'hB000_0000 + mcnt);
      exp_a = pat[i];
      #1;
      chk($sformatf("st%0d_alu_ready", i), 32'(alu_ready), 32'(exp_a));
      chk($sformatf("st%0d_mem_ready", i), 32'(mem_ready), 32'(!exp_a));
      @(posedge clk);
      #1;
      chk($sformatf("st%0d_rf_waddr", i), 32'(rf_waddr), exp_a ? 32'd1 : 32'd2);
      chk($sformatf("st%0d_rf_wdata", i), rf_wdata,
          exp_a ? 32'hA000_0000 + acnt : 32'hB000_0000 + mcnt);
      if (exp_a) acnt = acnt + 32'd1;
      else       mcnt = mcnt + 32'd1;
    end
    chk("st_conflict", 32'(conflict_cnt), 32'd10);

    // saturation of the conflict counter
    do_reset();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_conflict", 32'(conflict_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_conflict_hold", 32'(conflict_cnt), 32'hFFFF);

    // reset during a load grant to x7, right as starvation would flip priority
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd1, 32'hC0, 1'b1, (i == 3) ? 5'd7 : 5'd6, 32'hD0 + 32'(i));
      #1;
      chk($sformatf("mr%0d_mem_ready", i), 32'(mem_ready), 32'd1);
      if (i == 3) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("mr_rst_alu_ready", 32'(alu_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      if (i < 3) chk($sformatf("mr%0d_rf_we", i), 32'(rf_we), 32'd1);
    end
    chk("mr_no_write_we", 32'(rf_we), 32'd0);
    chk("mr_no_write_addr", 32'(rf_waddr), 32'd0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) rst_n = 1'b1;
      else drive(1'b1, 5'd1, 32'hC0, 1'b1, 5'd8, 32'hE0 + 32'(j));
      #1;
      chk($sformatf("ma%0d_alu_ready", j), 32'(alu_ready), (j == 4) ? 32'd1 : 32'd0);
      chk($sformatf("ma%0d_mem_ready", j), 32'(mem_ready), (j == 4) ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("ma%0d_rf_waddr", j), 32'(rf_waddr),
          (j == 4) ? 32'd1 : ((j == 0) ? 32'd7 : 32'd8));
      chk($sformatf("ma%0d_rf_we", j), 32'(rf_we), 32'd1);
    end
    if (n_cmp == 0) begin
      n_fail++;
      $display("FAIL no_checks: got 0 expected nonzero");
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback sources: the ALU result path and the memory-load result path.
- Both sources present results through a valid/ready handshake.
- Memory results normally win, because loads are long-latency and must not back up the memory stage. A starvation counter guarantees the ALU path a grant after a bounded wait.
- The winning result is registered onto the register-file write port. The block also keeps a saturating conflict counter for performance monitoring.

Parameters:
- DATA_W, 32, width of writeback data
- ADDR_W, 5, width of destination register index
- STARVE_LIMIT, 4, consecutive ALU denials before the ALU gets priority (legal range 1..15)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result pending
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU result accepted this cycle
- mem_valid  input  1  load result pending
- mem_rd  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- mem_ready  output  1  load result accepted this cycle
- rf_we  output  1  register-file write enable
- rf_waddr  output  ADDR_W  register-file write address
- rf_wdata  output  DATA_W  register-file write data
- conflict_cnt  output  16  saturating count of cycles with both sources valid

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
  - While rst_n is low: rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, state=MEM_PRI, starve_cnt=0, alu_ready=0, mem_ready=0.
- Handshake:
  - A transfer occurs when valid && ready.
  - A source holds valid, rd and data stable until its ready is seen.
  - ready is combinational from the valid inputs and state; it never asserts without the matching valid.
  - At most one ready is high per cycle.
- State machine, two states, MEM_PRI and ALU_PRI:
  - Only one source valid: that source is granted, in either state.
  - Both valid, MEM_PRI: grant mem.
  - Both valid, ALU_PRI: grant alu; next state MEM_PRI.
  - Neither valid: no grant; state holds.
- Starvation counter (starve_cnt, 4-bit internal):
  - Increments on each cycle with alu_valid && !alu_ready.
  - Cleared to 0 on any ALU grant.
  - When it increments to STARVE_LIMIT, next state is ALU_PRI.
- Output register, 1-cycle latency:
  - On the edge after a grant: rf_waddr and rf_wdata take the granted rd and data.
  - On that edge, rf_we = 1 if the granted rd != 0, else rf_we = 0. A write to x0 is still consumed (ready asserted) and still counts as a grant for starvation purposes.
  - No grant: rf_we = 0; rf_waddr and rf_wdata hold their previous values.
- conflict_cnt increments each cycle with alu_valid && mem_valid and saturates at 16'hFFFF.
- Same rd in both sources in the same cycle: the loser is written on a later cycle. Program-order correctness is the issuing stage's responsibility; this block only guarantees that each accepted result is written exactly once.
- Reset asserted mid-operation: any grant on that cycle is discarded and no write is produced. After release, arbitration restarts in MEM_PRI with starve_cnt=0.

Test Plan:
- Reset check: hold rst_n=0 with both valids high -> both readys 0, rf_we=0, conflict_cnt=0. Release -> mem granted on the first cycle.
- ALU only: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF for one cycle -> alu_ready=1 that cycle. Next edge: rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF. Following cycle rf_we=0.
- Starvation, STARVE_LIMIT=4: both valid for 10 cycles with fresh payloads -> grant sequence M,M,M,M,A,M,M,M,M,A; conflict_cnt=10.
- x0 write: mem_valid=1, mem_rd=0, mem_data=32'h1234 -> mem_ready=1, rf_we stays 0.
- Saturation: both valid for 70000 cycles -> conflict_cnt=16'hFFFF and holds.
- Mid-operation reset: pull rst_n low during a mem grant (mem_rd=7) -> no write to register 7. After release, state=MEM_PRI, and the held request is granted on the first cycle.
